// File: rtl/line_pkg.sv
// Shared widths, screen limits, command record and sequencer state type.
// LINE_SEQ_POLYLINE_EN adds a per-command chain bit to seg_cmd_t.
package line_pkg;

  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y1;
`ifdef LINE_SEQ_POLYLINE_EN
    logic           chain;
`endif
  } seg_cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StArm,
    StDraw,
    StRetire
  } seq_state_t;

endpackage

// File: rtl/seg_fifo.sv
// Synchronous FIFO of segment commands with a one-ahead read port so the
// sequencer can load the following command while retiring the current one.
module seg_fifo
  import line_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  seg_cmd_t               push_data,
  input  logic                   pop,
  output seg_cmd_t               head,
  output seg_cmd_t               head_next,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  seg_cmd_t        mem [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full      = (count_q == CntW'(Depth));
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head      = mem[rd_ptr_q];
  assign head_next = mem[rd_ptr_q + PtrW'(1)];
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/line_sequencer.sv
// Queues segment commands and launches them one at a time to a line drawer.
// Build option LINE_SEQ_POLYLINE_EN adds cmd_chain for joined polylines.
module line_sequencer
  import line_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [X_W-1:0] cmd_x0,
  input  logic [X_W-1:0] cmd_x1,
  input  logic [Y_W-1:0] cmd_y0,
  input  logic [Y_W-1:0] cmd_y1,
`ifdef LINE_SEQ_POLYLINE_EN
  input  logic           cmd_chain,
`endif
  output logic [X_W-1:0] x0,
  output logic [X_W-1:0] x1,
  output logic [Y_W-1:0] y0,
  output logic [Y_W-1:0] y1,
  output logic           nextstate,
  input  logic           write_done,
  output logic           busy,
  output logic [7:0]     seg_count,
  output logic           timeout_err
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t      state_q, state_d;
  seg_cmd_t        push_cmd, fifo_head, fifo_head_next, load_cmd;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [CntW-1:0] fifo_count;
  logic            load, timer_done, timeout_hit;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [X_W-1:0]  x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0]  y0_q, y0_d, y1_q, y1_d;
  logic [7:0]      seg_count_q, seg_count_d;
  logic            timeout_err_q, timeout_err_d;

  always_comb begin
    push_cmd    = '0;
    push_cmd.x0 = cmd_x0;
    push_cmd.y0 = cmd_y0;
    push_cmd.x1 = cmd_x1;
    push_cmd.y1 = cmd_y1;
`ifdef LINE_SEQ_POLYLINE_EN
    push_cmd.chain = cmd_chain;
`endif
  end

  seg_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_ready  = !fifo_full;
  assign timer_done = (timer_q == TmrW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    load        = 1'b0;
    load_cmd    = fifo_head;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StLaunch;
          load    = 1'b1;
        end
      end
      StLaunch: state_d = StArm;
      // A high write_done here is the previous segment's completion level.
      StArm: begin
        if (timer_done) begin
          state_d     = StRetire;
          timeout_hit = 1'b1;
        end else if (!write_done) begin
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (write_done) begin
          state_d = StRetire;
        end else if (timer_done) begin
          state_d     = StRetire;
          timeout_hit = 1'b1;
        end
      end
      StRetire: begin
        fifo_pop = 1'b1;
        // The head is still the retiring entry, so the next launch reads one ahead.
        if (fifo_count > CntW'(1)) begin
          state_d  = StLaunch;
          load     = 1'b1;
          load_cmd = fifo_head_next;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    x0_d = x0_q;
    y0_d = y0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    if (load) begin
      x0_d = load_cmd.x0;
      y0_d = load_cmd.y0;
      x1_d = load_cmd.x1;
      y1_d = load_cmd.y1;
`ifdef LINE_SEQ_POLYLINE_EN
      if (load_cmd.chain) begin
        x0_d = x1_q;
        y0_d = y1_q;
      end
`endif
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (load) begin
      timer_d = '0;
    end else if (state_q == StArm || state_q == StDraw) begin
      timer_d = timer_q + TmrW'(1);
    end
    seg_count_d   = seg_count_q + 8'(state_q == StRetire);
    timeout_err_d = timeout_err_q | timeout_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      x0_q          <= '0;
      y0_q          <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      seg_count_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      seg_count_q   <= seg_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign nextstate   = (state_q == StLaunch);
  assign busy        = (state_q != StIdle);
  assign x0          = x0_q;
  assign y0          = y0_q;
  assign x1          = x1_q;
  assign y1          = y1_q;
  assign seg_count   = seg_count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_line_sequencer.sv
// Bench for line_sequencer: behavioural drawer, launch scoreboard, vector table
// and directed multi-cycle sequences (define LINE_SEQ_POLYLINE_EN for chaining).
module tb_line_sequencer;
  import line_pkg::*;

`ifdef LINE_SEQ_POLYLINE_EN
  localparam bit PolyEn = 1'b1;
`else
  localparam bit PolyEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [X_W-1:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [Y_W-1:0] cmd_y0 = '0, cmd_y1 = '0;
`ifdef LINE_SEQ_POLYLINE_EN
  logic           cmd_chain = 1'b0;
`endif
  logic [X_W-1:0] x0, x1;
  logic [Y_W-1:0] y0, y1;
  logic           nextstate, busy, timeout_err;
  logic           write_done = 1'b1;
  logic [7:0]     seg_count;

  always #5 clk = ~clk;

  line_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x0      (cmd_x0),
    .cmd_x1      (cmd_x1),
    .cmd_y0      (cmd_y0),
    .cmd_y1      (cmd_y1),
`ifdef LINE_SEQ_POLYLINE_EN
    .cmd_chain   (cmd_chain),
`endif
    .x0          (x0),
    .x1          (x1),
    .y0          (y0),
    .y1          (y1),
    .nextstate   (nextstate),
    .write_done  (write_done),
    .busy        (busy),
    .seg_count   (seg_count),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y1;
  } pt_t;

  typedef struct {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y1;
    int             lat;
    logic [X_W-1:0] ex0;
    logic [Y_W-1:0] ey0;
    logic [X_W-1:0] ex1;
    logic [Y_W-1:0] ey1;
  } vec_t;

  int             tests = 0;
  int             fails = 0;
  pt_t            sb_q[$];
  pt_t            cur, mon_e;
  int             pulses = 0;
  int             unstable = 0;
  logic [X_W-1:0] last_x1 = '0;
  logic [Y_W-1:0] last_y1 = '0;
  int             drawer_lat = 5;
  int             stale_hold = 0;
  bit             never_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drawer model: drops write_done after a launch, raises it again after drawer_lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && nextstate) begin
        for (int i = 0; i < stale_hold && reset; i++) @(negedge clk);
        write_done = 1'b0;
        if (!never_done) begin
          for (int i = 0; i < drawer_lat && reset; i++) @(negedge clk);
          write_done = 1'b1;
        end
      end
    end
  end

  // Launch monitor: pops the scoreboard on each pulse and tracks endpoint stability.
  initial begin
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur = '{default: '0};
      end else if (nextstate) begin
        pulses++;
        if (sb_q.size() == 0) begin
          check("spurious_launch", nextstate, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("launch_x0", x0, mon_e.x0);
          check("launch_y0", y0, mon_e.y0);
          check("launch_x1", x1, mon_e.x1);
          check("launch_y1", y1, mon_e.y1);
          cur = mon_e;
        end
      end else if (x0 !== cur.x0 || y0 !== cur.y0 || x1 !== cur.x1 || y1 !== cur.y1) begin
        unstable++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1);
  end

  task automatic push_cmd(input logic [X_W-1:0] ax0, input logic [Y_W-1:0] ay0,
                          input logic [X_W-1:0] ax1, input logic [Y_W-1:0] ay1,
                          input logic chain);
    pt_t e;
    int  n;
    cmd_x0 = ax0;
    cmd_y0 = ay0;
    cmd_x1 = ax1;
    cmd_y1 = ay1;
`ifdef LINE_SEQ_POLYLINE_EN
    cmd_chain = chain;
`endif
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("push_accept", cmd_ready, 1);
    e.x0 = ax0;
    e.y0 = ay0;
    e.x1 = ax1;
    e.y1 = ay1;
    if (chain && PolyEn) begin
      e.x0 = last_x1;
      e.y0 = last_y1;
    end
    last_x1 = ax1;
    last_y1 = ay1;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_count(input int target, input int limit, input string name,
                            output int idle);
    int n;
    n    = 0;
    idle = 0;
    while (seg_count !== 8'(target) && n < limit) begin
      @(negedge clk);
      if (seg_count !== 8'(target) && !busy) idle++;
      n++;
    end
    check(name, seg_count, 8'(target));
  endtask

  vec_t vecs[5];
  int   exp_cnt = 0;
  int   idle, p0, n;

  initial begin
    vecs[0] = '{639, 479, 0, 0, 3, 639, 479, 0, 0};
    vecs[1] = '{1023, 511, 1, 2, 2, 1023, 511, 1, 2};
    vecs[2] = '{0, 0, 639, 479, 7, 0, 0, 639, 479};
    vecs[3] = '{700, 500, 320, 240, 12, 700, 500, 320, 240};
    vecs[4] = '{320, 240, 320, 240, 2, 320, 240, 320, 240};

    // Held in reset
    repeat (3) @(negedge clk);
    check("rst_nextstate", nextstate, 0);
    check("rst_busy", busy, 0);
    check("rst_seg_count", seg_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_x0", x0, 0);
    check("rst_y1", y1, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // Single segment, 231-cycle draw
    drawer_lat = 231;
    p0 = pulses;
    push_cmd(10, 10, 240, 10, 1'b0);
    exp_cnt++;
    wait_count(exp_cnt, 600, "single_count", idle);
    check("single_busy_after", busy, 0);
    check("single_pulses", pulses - p0, 1);
    repeat (3) @(negedge clk);
    check("single_hold_x0", x0, 10);
    check("single_hold_x1", x1, 240);

    // Vector table, including out-of-range pass-through
    for (int i = 0; i < 5; i++) begin
      drawer_lat = vecs[i].lat;
      push_cmd(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, 1'b0);
      exp_cnt++;
      wait_count(exp_cnt, 300, $sformatf("vec%0d_count", i), idle);
      check($sformatf("vec%0d_x0", i), x0, vecs[i].ex0);
      check($sformatf("vec%0d_y0", i), y0, vecs[i].ey0);
      check($sformatf("vec%0d_x1", i), x1, vecs[i].ex1);
      check($sformatf("vec%0d_y1", i), y1, vecs[i].ey1);
    end

    // Four back-to-back commands fill the FIFO while the first draws
    drawer_lat = 20;
    p0 = pulses;
    push_cmd(1, 2, 3, 4, 1'b0);
    push_cmd(5, 6, 7, 8, 1'b0);
    push_cmd(9, 10, 11, 12, 1'b0);
    push_cmd(13, 14, 15, 16, 1'b0);
    check("b2b_ready_full", cmd_ready, 0);
    exp_cnt += 4;
    wait_count(exp_cnt, 1000, "b2b_count", idle);
    check("b2b_idle_gaps", idle, 0);
    check("b2b_pulses", pulses - p0, 4);

    // Stale write_done held high across launch must not retire the segment
    stale_hold = 6;
    drawer_lat = 5;
    push_cmd(100, 100, 200, 200, 1'b0);
    repeat (5) @(negedge clk);
    check("stale_no_retire", seg_count, 8'(exp_cnt));
    check("stale_busy", busy, 1);
    exp_cnt++;
    wait_count(exp_cnt, 100, "stale_count", idle);
    stale_hold = 0;

    // Drawer never completes: timeout, then the queued segment launches
    never_done = 1'b1;
    drawer_lat = 6;
    push_cmd(50, 60, 70, 80, 1'b0);
    n = 0;
    while (!nextstate && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("to_launch_seen", nextstate, 1);
    push_cmd(90, 91, 92, 93, 1'b0);
    n = 1;
    while (!timeout_err && n < 1100) begin
      @(negedge clk);
      n++;
    end
    never_done = 1'b0;
    check("to_err_set", timeout_err, 1);
    check("to_latency_window", (n >= 1018 && n <= 1030), 1);
    exp_cnt += 2;
    wait_count(exp_cnt, 200, "to_count", idle);
    check("to_err_sticky", timeout_err, 1);

    // Reset during DRAW with three more entries queued
    drawer_lat = 300;
    push_cmd(11, 12, 13, 14, 1'b0);
    push_cmd(21, 22, 23, 24, 1'b0);
    push_cmd(31, 32, 33, 34, 1'b0);
    push_cmd(41, 42, 43, 44, 1'b0);
    repeat (10) @(negedge clk);
    check("rst2_pre_busy", busy, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst2_nextstate", nextstate, 0);
    check("rst2_busy", busy, 0);
    check("rst2_seg_count", seg_count, 0);
    check("rst2_timeout_err", timeout_err, 0);
    check("rst2_x0", x0, 0);
    check("rst2_y0", y0, 0);
    check("rst2_x1", x1, 0);
    check("rst2_y1", y1, 0);
    check("rst2_cmd_ready", cmd_ready, 1);
    sb_q.delete();
    exp_cnt = 0;
    last_x1 = '0;
    last_y1 = '0;
    @(negedge clk);
    reset = 1'b1;
    p0 = pulses;
    repeat (30) @(negedge clk);
    check("rst2_no_launch", pulses - p0, 0);
    check("rst2_idle", busy, 0);

    // First command after reset; chained case starts from the origin
    drawer_lat = 4;
    push_cmd(5, 5, 30, 30, PolyEn);
    exp_cnt++;
    wait_count(exp_cnt, 100, "post_rst_count", idle);
    check("post_rst_x0", x0, PolyEn ? 0 : 5);

`ifdef LINE_SEQ_POLYLINE_EN
    // Chained segment starts at the previous segment's end point
    push_cmd(0, 0, 100, 50, 1'b0);
    push_cmd(7, 7, 200, 20, 1'b1);
    exp_cnt += 2;
    wait_count(exp_cnt, 200, "poly_count", idle);
    check("poly_x0", x0, 100);
    check("poly_y0", y0, 50);
    check("poly_x1", x1, 200);
    check("poly_y1", y1, 20);
`endif

    check("endpoints_stable", unstable, 0);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
